mem_ctrl: RTL and testbench

- Responder side of the load/store buffer's memory request interface (ls_*), and of the instruction fetcher's word-read interface (if_*).
- Serialises each request into byte accesses on the single 8-bit RAM/IO port; assembles little-endian read data and returns it with a one-cycle valid pulse.
- Sits between the core (SLB, IF) and the external RAM/IO bus.

---
 rtl/mem_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_mem_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serialising memory controller for the load/store buffer and instruction fetcher
// Optional IO write stall on io_buffer_full: define MEM_CTRL_IO_STALL_EN.
module mem_ctrl #(
    parameter logic [1:0] IO_HI_BITS = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    input  logic        if_enable,
    input  logic [31:0] if_addr,
    output logic        if_valid,
    output logic [31:0] if_dout,
    input  logic        ls_enable,
    input  logic [2:0]  ls_siz,
    input  logic [31:0] ls_addr,
    input  logic        ls_wr_tag,
    input  logic [31:0] ls_din,
    output logic        ls_valid,
    output logic [31:0] ls_dout,
    input  logic [7:0]  ram_din,
    output logic [7:0]  ram_dout,
    output logic [31:0] ram_a,
    output logic        ram_wr,
    input  logic        io_buffer_full
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;

    logic [1:0]  state;
    logic        src_if;
    logic [2:0]  cnt;
    logic [2:0]  len;
    logic [31:0] addr_q;
    logic [31:0] din_q;
    logic [31:0] data_q;
    logic [31:0] data_next;
    logic [7:0]  wr_byte;
    logic        ram_wr_q;
    logic        accept_stall;
    logic        wr_stall;

`ifdef MEM_CTRL_IO_STALL_EN
    assign accept_stall = (ls_addr[17:16] == IO_HI_BITS) && io_buffer_full;
    assign wr_stall     = (addr_q[17:16] == IO_HI_BITS) && io_buffer_full;
`else
    logic unused_io_buffer_full;
    assign unused_io_buffer_full = io_buffer_full;
    assign accept_stall = 1'b0;
    assign wr_stall     = 1'b0;
`endif

    // Frozen cycles must never write, even though the registered strobe holds.
    assign ram_wr = ram_wr_q & rdy;

    // Byte k arrives two edges after its address was issued, so cnt lags by two.
    always_comb begin
        data_next = data_q;
        case (cnt)
            3'd2:    data_next[7:0]   = ram_din;
            3'd3:    data_next[15:8]  = ram_din;
            3'd4:    data_next[23:16] = ram_din;
            3'd5:    data_next[31:24] = ram_din;
            default: data_next = data_q;
        endcase
    end

    always_comb begin
        wr_byte = din_q[7:0];
        case (cnt)
            3'd1:    wr_byte = din_q[15:8];
            3'd2:    wr_byte = din_q[23:16];
            3'd3:    wr_byte = din_q[31:24];
            default: wr_byte = din_q[7:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            src_if   <= 1'b0;
            cnt      <= 3'd0;
            len      <= 3'd0;
            addr_q   <= 32'd0;
            din_q    <= 32'd0;
            data_q   <= 32'd0;
            if_valid <= 1'b0;
            if_dout  <= 32'd0;
            ls_valid <= 1'b0;
            ls_dout  <= 32'd0;
            ram_dout <= 8'd0;
            ram_a    <= 32'd0;
            ram_wr_q <= 1'b0;
        end else if (rdy) begin
            if_valid <= 1'b0;
            ls_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    ram_wr_q <= 1'b0;
                    ram_a    <= 32'd0;
                    // Requesters still hold enable during the valid cycle; skip it.
                    if (!if_valid && !ls_valid) begin
                        if (ls_enable) begin
                            src_if <= 1'b0;
                            addr_q <= ls_addr;
                            din_q  <= ls_din;
                            len    <= ls_siz;
                            data_q <= 32'd0;
                            if (ls_wr_tag) begin
                                state <= S_WR;
                                if (accept_stall) begin
                                    cnt <= 3'd0;
                                end else begin
                                    cnt      <= 3'd1;
                                    ram_wr_q <= 1'b1;
                                    ram_a    <= ls_addr;
                                    ram_dout <= ls_din[7:0];
                                end
                            end else begin
                                state <= S_RD;
                                cnt   <= 3'd1;
                                ram_a <= ls_addr;
                            end
                        end else if (if_enable && !flush) begin
                            src_if <= 1'b1;
                            addr_q <= if_addr;
                            len    <= 3'd4;
                            data_q <= 32'd0;
                            state  <= S_RD;
                            cnt    <= 3'd1;
                            ram_a  <= if_addr;
                        end
                    end
                end
                S_RD: begin
                    if (src_if && flush) begin
                        state <= S_IDLE;
                        cnt   <= 3'd0;
                        ram_a <= 32'd0;
                    end else begin
                        data_q <= data_next;
                        if (cnt == len + 3'd1) begin
                            state <= S_IDLE;
                            cnt   <= 3'd0;
                            if (src_if) begin
                                if_valid <= 1'b1;
                                if_dout  <= data_next;
                            end else begin
                                ls_valid <= 1'b1;
                                ls_dout  <= data_next;
                            end
                        end else begin
                            cnt   <= cnt + 3'd1;
                            ram_a <= (cnt < len) ? addr_q + {29'd0, cnt} : 32'd0;
                        end
                    end
                end
                S_WR: begin
                    if (cnt == len) begin
                        state    <= S_IDLE;
                        cnt      <= 3'd0;
                        ram_wr_q <= 1'b0;
                        ram_a    <= 32'd0;
                        ls_valid <= 1'b1;
                    end else if (wr_stall) begin
                        ram_wr_q <= 1'b0;
                    end else begin
                        ram_wr_q <= 1'b1;
                        ram_a    <= addr_q + {29'd0, cnt};
                        ram_dout <= wr_byte;
                        cnt      <= cnt + 3'd1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    cnt      <= 3'd0;
                    ram_wr_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed self-checking bench for mem_ctrl
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        flush = 1'b0;
    logic        if_enable = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_valid;
    logic [31:0] if_dout;
    logic        ls_enable = 1'b0;
    logic [2:0]  ls_siz = 3'd0;
    logic [31:0] ls_addr = 32'd0;
    logic        ls_wr_tag = 1'b0;
    logic [31:0] ls_din = 32'd0;
    logic        ls_valid;
    logic [31:0] ls_dout;
    logic [7:0]  ram_din = 8'd0;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic        io_buffer_full = 1'b0;

    logic [7:0]  mem [0:65535];
    logic        pl_we = 1'b0;
    logic [15:0] pl_a = 16'd0;
    logic [7:0]  pl_d = 8'd0;
    int          wr_count = 0;
    int          checks = 0;
    int          errors = 0;
    int          w0;
    int          cyc;
    int          hits;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .if_enable(if_enable), .if_addr(if_addr), .if_valid(if_valid), .if_dout(if_dout),
        .ls_enable(ls_enable), .ls_siz(ls_siz), .ls_addr(ls_addr), .ls_wr_tag(ls_wr_tag),
        .ls_din(ls_din), .ls_valid(ls_valid), .ls_dout(ls_dout),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    // Synchronous byte RAM: one-cycle read latency, write on ram_wr.
    always @(posedge clk) begin
        if (pl_we) mem[pl_a] <= pl_d;
        else if (ram_wr) mem[ram_a[15:0]] <= ram_dout;
        if (ram_wr) wr_count <= wr_count + 1;
        ram_din <= mem[ram_a[15:0]];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        pl_we = 1'b1;
        pl_a  = a;
        pl_d  = d;
        tick;
        pl_we = 1'b0;
    endtask

    task automatic wait_valid(input bit is_if, input int budget, output int cycles);
        cycles = 0;
        while (cycles < budget) begin
            tick;
            cycles++;
            if (is_if ? if_valid : ls_valid) break;
        end
    endtask

    task automatic ls_req(input logic wr, input logic [2:0] siz, input logic [31:0] a, input logic [31:0] d);
        ls_enable = 1'b1;
        ls_wr_tag = wr;
        ls_siz    = siz;
        ls_addr   = a;
        ls_din    = d;
    endtask

    initial begin
        tick;
        preload(16'h1000, 8'h11); preload(16'h1001, 8'h22);
        preload(16'h1002, 8'h33); preload(16'h1003, 8'h44);
        preload(16'h0000, 8'h93); preload(16'h0001, 8'h00);
        preload(16'h0002, 8'h00); preload(16'h0003, 8'h00);
        preload(16'h0010, 8'hA5);
        preload(16'h0040, 8'hEF); preload(16'h0041, 8'hBE);
        preload(16'h0042, 8'hAD); preload(16'h0043, 8'hDE);
        preload(16'h0080, 8'h13); preload(16'h0081, 8'h05);
        preload(16'h0082, 8'h10); preload(16'h0083, 8'h00);

        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_ls_valid", 32'(ls_valid), 32'd0);
        check("rst_ram_wr",   32'(ram_wr),   32'd0);
        check("rst_ram_a",    ram_a,         32'd0);
        check("rst_ram_dout", 32'(ram_dout), 32'd0);
        check("rst_if_dout",  if_dout,       32'd0);
        check("rst_ls_dout",  ls_dout,       32'd0);
        rst = 1'b0;
        tick;

        // LW 0x1000
        ls_req(1'b0, 3'd4, 32'h1000, 32'd0);
        tick;
        for (int k = 0; k < 4; k++) begin
            check("lw_ram_a", ram_a, 32'h1000 + 32'(k));
            check("lw_ram_wr", 32'(ram_wr), 32'd0);
            check("lw_early_valid", 32'(ls_valid), 32'd0);
            tick;
        end
        check("lw_valid_e4", 32'(ls_valid), 32'd0);
        tick;
        check("lw_valid", 32'(ls_valid), 32'd1);
        check("lw_dout", ls_dout, 32'h44332211);
        check("lw_if_valid", 32'(if_valid), 32'd0);
        tick;
        check("lw_pulse_len", 32'(ls_valid), 32'd0);
        check("lw_no_reaccept", ram_a, 32'd0);
        ls_enable = 1'b0;
        tick;

        // SH 0x2002
        w0 = wr_count;
        ls_req(1'b1, 3'd2, 32'h2002, 32'hDEADBEEF);
        tick;
        check("sh_wr0", 32'(ram_wr), 32'd1);
        check("sh_a0", ram_a, 32'h2002);
        check("sh_d0", 32'(ram_dout), 32'hEF);
        tick;
        check("sh_wr1", 32'(ram_wr), 32'd1);
        check("sh_a1", ram_a, 32'h2003);
        check("sh_d1", 32'(ram_dout), 32'hBE);
        tick;
        check("sh_wr_end", 32'(ram_wr), 32'd0);
        check("sh_valid", 32'(ls_valid), 32'd1);
        tick;
        check("sh_pulse_len", 32'(ls_valid), 32'd0);
        check("sh_no_third", 32'(ram_wr), 32'd0);
        ls_enable = 1'b0;
        check("sh_count", 32'(wr_count - w0), 32'd2);
        check("sh_mem", {24'd0, mem[16'h2003], mem[16'h2002]}, 32'h0000BEEF);

        // LB 0x10 and fetch 0x0 together: LS first
        ls_req(1'b0, 3'd1, 32'h10, 32'd0);
        if_enable = 1'b1;
        if_addr   = 32'h0;
        tick;
        check("prio_ram_a", ram_a, 32'h10);
        tick;
        tick;
        check("prio_ls_valid", 32'(ls_valid), 32'd1);
        check("prio_ls_dout", ls_dout, 32'h000000A5);
        check("prio_if_valid", 32'(if_valid), 32'd0);
        tick;
        ls_enable = 1'b0;
        wait_valid(1'b1, 12, cyc);
        check("if0_latency", 32'(cyc), 32'd6);
        check("if0_dout", if_dout, 32'h00000093);
        tick;
        check("if0_pulse_len", 32'(if_valid), 32'd0);
        if_enable = 1'b0;

        // Fetch 0x40 aborted by flush
        if_enable = 1'b1;
        if_addr   = 32'h40;
        tick;
        check("fl_a0", ram_a, 32'h40);
        tick;
        check("fl_a1", ram_a, 32'h41);
        flush = 1'b1;
        tick;
        check("fl_idle_a", ram_a, 32'd0);
        flush = 1'b0;
        if_enable = 1'b0;
        hits = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (if_valid) hits++;
        end
        check("fl_no_if_valid", 32'(hits), 32'd0);
        if_enable = 1'b1;
        if_addr   = 32'h80;
        wait_valid(1'b1, 12, cyc);
        check("if80_latency", 32'(cyc), 32'd6);
        check("if80_dout", if_dout, 32'h00100513);
        tick;
        if_enable = 1'b0;

        // Flush blocks a fetch accept in IDLE
        if_enable = 1'b1;
        if_addr   = 32'h84;
        flush     = 1'b1;
        tick;
        check("fl_idle_no_accept", ram_a, 32'd0);
        if_enable = 1'b0;
        flush     = 1'b0;
        tick;

        // SB with flush mid-write still completes
        w0 = wr_count;
        ls_req(1'b1, 3'd1, 32'h2010, 32'h0000005A);
        tick;
        check("sbf_wr", 32'(ram_wr), 32'd1);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        check("sbf_valid", 32'(ls_valid), 32'd1);
        tick;
        ls_enable = 1'b0;
        check("sbf_count", 32'(wr_count - w0), 32'd1);
        check("sbf_mem", {24'd0, mem[16'h2010]}, 32'h5A);

        // SW 0x3000 with rdy low for 3 cycles
        w0 = wr_count;
        ls_req(1'b1, 3'd4, 32'h3000, 32'h87654321);
        tick;
        check("sw_a0", ram_a, 32'h3000);
        check("sw_d0", 32'(ram_dout), 32'h21);
        tick;
        check("sw_a1", ram_a, 32'h3001);
        rdy = 1'b0;
        #1;
        check("sw_frozen_wr", 32'(ram_wr), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick;
            check("sw_stall_wr", 32'(ram_wr), 32'd0);
            check("sw_stall_a", ram_a, 32'h3001);
        end
        rdy = 1'b1;
        #1;
        check("sw_resume_wr", 32'(ram_wr), 32'd1);
        check("sw_resume_d", 32'(ram_dout), 32'h43);
        tick;
        check("sw_a2", ram_a, 32'h3002);
        check("sw_d2", 32'(ram_dout), 32'h65);
        tick;
        check("sw_a3", ram_a, 32'h3003);
        check("sw_d3", 32'(ram_dout), 32'h87);
        tick;
        check("sw_valid", 32'(ls_valid), 32'd1);
        check("sw_end_wr", 32'(ram_wr), 32'd0);
        tick;
        ls_enable = 1'b0;
        check("sw_count", 32'(wr_count - w0), 32'd4);
        check("sw_mem", {mem[16'h3003], mem[16'h3002], mem[16'h3001], mem[16'h3000]}, 32'h87654321);

        // SB to IO region with io_buffer_full
        w0 = wr_count;
        io_buffer_full = 1'b1;
        ls_req(1'b1, 3'd1, 32'h30000, 32'h00000077);
`ifdef MEM_CTRL_IO_STALL_EN
        for (int i = 0; i < 4; i++) begin
            tick;
            check("io_stall_wr", 32'(ram_wr), 32'd0);
            check("io_stall_valid", 32'(ls_valid), 32'd0);
        end
        io_buffer_full = 1'b0;
        tick;
`else
        tick;
`endif
        check("io_wr", 32'(ram_wr), 32'd1);
        check("io_a", ram_a, 32'h30000);
        check("io_d", 32'(ram_dout), 32'h77);
        io_buffer_full = 1'b0;
        tick;
        check("io_valid", 32'(ls_valid), 32'd1);
        check("io_end_wr", 32'(ram_wr), 32'd0);
        tick;
        ls_enable = 1'b0;
        check("io_count", 32'(wr_count - w0), 32'd1);
        tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
